// File: rtl/rs_issue_scheduler.sv
// Round-robin issue scheduler for reservation stations sharing one execution unit.
// Also allocates the lowest free RS to the decode instruction.
module rs_issue_scheduler #(
  parameter int unsigned NUM_RS   = 4,
  parameter int unsigned LONG_LAT = 3
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      needToRestore_i,
  input  logic                      decodeValid_i,
  input  logic [NUM_RS-1:0]         rsBusy_i,
  input  logic [NUM_RS-1:0]         rsReady_i,
  input  logic [NUM_RS-1:0]         rsLongOp_i,
  output logic [NUM_RS-1:0]         rsWriteEn_o,
  output logic                      decodeStall_o,
  output logic [NUM_RS-1:0]         rsStall_o,
  output logic                      issueValid_o,
  output logic [$clog2(NUM_RS)-1:0] issueSel_o
);

  localparam int unsigned IdxW = $clog2(NUM_RS);
  localparam int unsigned CntW = $clog2(LONG_LAT);

  logic [IdxW-1:0]   r_ptr;
  logic [CntW-1:0]   r_busy;

  logic [NUM_RS-1:0] w_elig;
  logic              w_found;
  logic [IdxW-1:0]   w_grant;
  int unsigned       w_j;
  logic              w_block;
  logic              w_issue;
  logic              w_alloc_done;

  assign w_elig  = rsBusy_i & rsReady_i;
  assign w_block = reset_i | needToRestore_i | (r_busy != '0);
  assign w_issue = w_found & ~w_block;

  // Round-robin search starting at r_ptr, wrapping past NUM_RS-1 to 0.
  always_comb begin
    w_found = 1'b0;
    w_grant = '0;
    w_j     = 0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      w_j = int'(unsigned'(r_ptr)) + k;
      if (w_j >= NUM_RS) w_j = w_j - NUM_RS;
      if (!w_found && w_elig[IdxW'(w_j)]) begin
        w_found = 1'b1;
        w_grant = IdxW'(w_j);
      end
    end
  end

  always_comb begin
    issueValid_o = w_issue;
    issueSel_o   = w_issue ? w_grant : '0;
    rsStall_o    = '1;
    if (w_issue) rsStall_o[w_grant] = 1'b0;
  end

  // Allocation looks only at rsBusy_i, so an RS freed by this cycle's issue is not reused.
  always_comb begin
    rsWriteEn_o  = '0;
    w_alloc_done = 1'b0;
    if (decodeValid_i && !needToRestore_i && !reset_i) begin
      for (int unsigned i = 0; i < NUM_RS; i++) begin
        if (!w_alloc_done && !rsBusy_i[i]) begin
          rsWriteEn_o[i] = 1'b1;
          w_alloc_done   = 1'b1;
        end
      end
    end
  end

  assign decodeStall_o = reset_i | (decodeValid_i & (&rsBusy_i));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ptr  <= '0;
      r_busy <= '0;
    end else if (needToRestore_i) begin
      r_busy <= '0;
    end else if (r_busy != '0) begin
      r_busy <= r_busy - CntW'(1);
    end else if (w_issue) begin
      r_ptr <= (w_grant == IdxW'(NUM_RS - 1)) ? '0 : w_grant + IdxW'(1);
      if (rsLongOp_i[w_grant]) r_busy <= CntW'(LONG_LAT - 1);
    end
  end

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Self-checking bench for rs_issue_scheduler: directed scenarios plus randomized traffic
// compared against an integer-level reference model.
module tb_rs_issue_scheduler;

  localparam int N  = 4;
  localparam int LL = 3;
  localparam int SW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset_i;
  logic          needToRestore_i;
  logic          decodeValid_i;
  logic [N-1:0]  rsBusy_i;
  logic [N-1:0]  rsReady_i;
  logic [N-1:0]  rsLongOp_i;
  logic [N-1:0]  rsWriteEn_o;
  logic          decodeStall_o;
  logic [N-1:0]  rsStall_o;
  logic          issueValid_o;
  logic [SW-1:0] issueSel_o;

  rs_issue_scheduler #(
    .NUM_RS   (N),
    .LONG_LAT (LL)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .needToRestore_i (needToRestore_i),
    .decodeValid_i   (decodeValid_i),
    .rsBusy_i        (rsBusy_i),
    .rsReady_i       (rsReady_i),
    .rsLongOp_i      (rsLongOp_i),
    .rsWriteEn_o     (rsWriteEn_o),
    .decodeStall_o   (decodeStall_o),
    .rsStall_o       (rsStall_o),
    .issueValid_o    (issueValid_o),
    .issueSel_o      (issueSel_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: round-robin pointer and remaining long-op busy cycles.
  int m_ptr  = 0;
  int m_busy = 0;
  int nxt_ptr;
  int nxt_busy;

  logic [3:0] stall_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Waits for the falling edge, compares all outputs with the model, prepares next state.
  task automatic sample(input string tag);
    int         grant;
    bit         blocked;
    bit         e_valid;
    int         e_sel;
    logic [N-1:0] e_stall;
    logic [N-1:0] e_we;
    bit         e_dstall;
    bit         done;
    @(negedge clk);
    grant = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_ptr + k) % N;
      if (grant < 0 && rsBusy_i[j] && rsReady_i[j]) grant = j;
    end
    blocked = reset_i || needToRestore_i || (m_busy > 0);
    e_valid = !blocked && (grant >= 0);
    e_sel   = e_valid ? grant : 0;
    e_stall = '1;
    if (e_valid) e_stall[grant] = 1'b0;
    e_we = '0;
    done = 0;
    if (!reset_i && !needToRestore_i && decodeValid_i) begin
      for (int i = 0; i < N; i++) begin
        if (!done && !rsBusy_i[i]) begin
          e_we[i] = 1'b1;
          done    = 1;
        end
      end
    end
    e_dstall = reset_i || (decodeValid_i && (rsBusy_i == '1));
    check_eq({tag, ".valid"},  32'(issueValid_o),  32'(e_valid));
    check_eq({tag, ".sel"},    32'(issueSel_o),    32'(e_sel));
    check_eq({tag, ".stall"},  32'(rsStall_o),     32'(e_stall));
    check_eq({tag, ".we"},     32'(rsWriteEn_o),   32'(e_we));
    check_eq({tag, ".dstall"}, 32'(decodeStall_o), 32'(e_dstall));
    nxt_ptr  = m_ptr;
    nxt_busy = m_busy;
    if (reset_i) begin
      nxt_ptr  = 0;
      nxt_busy = 0;
    end else if (needToRestore_i) begin
      nxt_busy = 0;
    end else if (m_busy > 0) begin
      nxt_busy = m_busy - 1;
    end else if (e_valid) begin
      nxt_ptr  = (grant + 1) % N;
      nxt_busy = rsLongOp_i[grant] ? LL - 1 : 0;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    m_ptr  = nxt_ptr;
    m_busy = nxt_busy;
    #1;
  endtask

  task automatic drive(input logic rst, input logic rest, input logic dv,
                       input logic [N-1:0] busy, input logic [N-1:0] rdy,
                       input logic [N-1:0] lng);
    reset_i         = rst;
    needToRestore_i = rest;
    decodeValid_i   = dv;
    rsBusy_i        = busy;
    rsReady_i       = rdy;
    rsLongOp_i      = lng;
    if (rst) begin
      m_ptr  = 0;
      m_busy = 0;
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000);
    #1;
    sample("reset");
    check_eq("reset.dstall_const", 32'(decodeStall_o), 32'd1);
    advance();
    reset_i = 1'b0;

    // Round-robin across all four stations from a fresh pointer.
    drive(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1111, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      sample("rr");
      check_eq("rr.sel_seq",   32'(issueSel_o), 32'(i));
      check_eq("rr.stall_seq", 32'(rsStall_o),  32'(stall_tab[i]));
      advance();
    end

    // Move pointer to 2, then check wrap to RS0.
    drive(1'b0, 1'b0, 1'b0, 4'b0010, 4'b0010, 4'b0000);
    sample("to2");
    advance();
    drive(1'b0, 1'b0, 1'b0, 4'b0011, 4'b0011, 4'b0000);
    sample("wrap");
    check_eq("wrap.sel0", 32'(issueSel_o), 32'd0);
    advance();

    // Pointer now 1: RS1 wins over RS0/RS2 and starts a long op.
    drive(1'b0, 1'b0, 1'b0, 4'b0111, 4'b0111, 4'b0010);
    sample("long_start");
    check_eq("long_start.sel1", 32'(issueSel_o), 32'd1);
    advance();
    drive(1'b0, 1'b0, 1'b0, 4'b0101, 4'b0101, 4'b0000);
    for (int i = 0; i < 2; i++) begin
      sample("long_hold");
      check_eq("long_hold.valid0", 32'(issueValid_o), 32'd0);
      advance();
    end
    sample("long_done");
    check_eq("long_done.valid1", 32'(issueValid_o), 32'd1);
    check_eq("long_done.sel2",   32'(issueSel_o),   32'd2);
    advance();

    // Allocation and decode stall.
    drive(1'b0, 1'b0, 1'b1, 4'b1011, 4'b0000, 4'b0000);
    sample("alloc");
    check_eq("alloc.we", 32'(rsWriteEn_o), 32'b0100);
    advance();
    drive(1'b0, 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000);
    sample("full");
    check_eq("full.dstall", 32'(decodeStall_o), 32'd1);
    check_eq("full.we0",    32'(rsWriteEn_o),   32'd0);
    advance();

    // Restore in the middle of a long op (pointer is 3, RS0 issues long).
    drive(1'b0, 1'b0, 1'b0, 4'b0001, 4'b0001, 4'b0001);
    sample("rst_long");
    advance();
    drive(1'b0, 1'b1, 1'b1, 4'b0111, 4'b0111, 4'b0000);
    sample("restore");
    check_eq("restore.we0",    32'(rsWriteEn_o),  32'd0);
    check_eq("restore.valid0", 32'(issueValid_o), 32'd0);
    check_eq("restore.stall",  32'(rsStall_o),    32'b1111);
    advance();
    drive(1'b0, 1'b0, 1'b0, 4'b0111, 4'b0111, 4'b0000);
    sample("post_restore");
    check_eq("post_restore.valid1", 32'(issueValid_o), 32'd1);
    check_eq("post_restore.sel1",   32'(issueSel_o),   32'd1);
    advance();

    // Asynchronous reset between edges during a busy count.
    drive(1'b0, 1'b0, 1'b0, 4'b0100, 4'b0100, 4'b0100);
    sample("ar_long");
    advance();
    drive(1'b0, 1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0000);
    sample("ar_busy");
    #2;
    drive(1'b1, 1'b0, 1'b1, 4'b0111, 4'b0111, 4'b0000);
    #1;
    check_eq("ar.valid0",  32'(issueValid_o),  32'd0);
    check_eq("ar.sel0",    32'(issueSel_o),    32'd0);
    check_eq("ar.stall",   32'(rsStall_o),     32'b1111);
    check_eq("ar.we0",     32'(rsWriteEn_o),   32'd0);
    check_eq("ar.dstall1", 32'(decodeStall_o), 32'd1);
    nxt_ptr  = 0;
    nxt_busy = 0;
    advance();
    #2;
    reset_i = 1'b0;
    sample("ar_release");
    check_eq("ar_release.valid1", 32'(issueValid_o), 32'd1);
    check_eq("ar_release.sel0",   32'(issueSel_o),   32'd0);
    advance();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) == 0),
            1'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      sample("rand");
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
